multi_timer_periph: RTL and testbench
=====================================

Name: multi_timer_periph

Overview:
- Parametrised successor to the single-timer section of the memory-mapped peripheral block.
- Provides NUM_CH independent up-counting timers on the CPU load/store bus: TH reload, TL count, TCON control, per-channel prescaler, one-shot/auto-reload mode and write-1-to-clear interrupt flags.
- All flags combine into one irqout line to the CPU interrupt logic.
- Sits beside the existing LED/switch/digit/UART decode, in its own address window.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 32, timer counter width in bits (8..32).
- PRE_W, 16, prescaler width in bits (1..16).
- BASE_ADDR, 32'h40000100, byte address of channel 0's register block.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd  in  1  bus read strobe.
- wr  in  1  bus write strobe, one cycle per write.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational.
- irqout  out  1  OR over channels of (TCON.flag & TCON.ie).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high; reset port is named reset.
- Reset values: all TH, TL, PRE, prescale counters and TCON = 0; irqout = 0; rdata = 0 while rd = 0.
- Address map:
  - Channel c occupies BASE_ADDR + 16*c.
  - +0x0 TH: reload value, CNT_W bits.
  - +0x4 TL: current count.
  - +0x8 TCON: [0] en, [1] ie, [2] flag, [3] oneshot.
  - +0xC PRE: prescale divisor, PRE_W bits.
  - BASE_ADDR + 0x80 STAT: read-only; bit c = flag of channel c.
  - Unmapped addresses inside or outside the window: read 0, writes ignored.
- Reads: rdata = zero-extended register when rd = 1 and the address hits, else 0. No side effects on read.
- Writes: take effect at the next clk edge.
  - TCON write sets en, ie and oneshot from wdata.
  - wdata[2] = 1 clears flag (W1C); wdata[2] = 0 leaves flag unchanged.
  - Upper wdata bits beyond the register width are dropped.
- Prescaler, per channel, only while en = 1:
  - pcnt counts 0..PRE.
  - A tick is asserted on the cycle pcnt == PRE, and pcnt returns to 0.
  - PRE = 0 gives a tick every cycle.
  - Writing PRE or TCON resets pcnt to 0.
- Count on tick:
  - If TL == all-ones(CNT_W): TL <= TH and flag <= 1, set regardless of ie (ie gates irqout only).
  - If oneshot = 1, en <= 0 in the same cycle.
  - Otherwise TL <= TL + 1, wrapping within CNT_W.
- en = 0: TL and pcnt hold.
- Overflow latency: the flag is visible, and irqout rises, the cycle after the edge on which TL was all-ones with tick = 1.
- Simultaneous events on one edge:
  - Bus write to TL vs tick: the write wins; no overflow is processed that cycle.
  - W1C to flag vs overflow: the set wins; flag stays 1.
  - TCON write with en = 1 vs oneshot overflow: the written en wins.
  - Write to TH vs overflow: TL loads the old TH; the new TH applies to later reloads.
- Channels are fully independent; a write touches exactly one register.
- reset asserted mid-count: all state returns to its reset value immediately, without waiting for clk.

Decomposition:
- Shared package multi_timer_pkg holds:
  - register offset constants: OFF_TH = 0x0, OFF_TL = 0x4, OFF_TCON = 0x8, OFF_PRE = 0xC, OFF_STAT = 0x80, CH_STRIDE = 16;
  - TCON bit index constants: EN = 0, IE = 1, FLAG = 2, ONESHOT = 3.
- One sub-module, timer_channel: parametrised by CNT_W and PRE_W; holds TH, TL, PRE, pcnt and TCON; inputs are per-channel write enables plus wdata.
- The top level instantiates NUM_CH copies and handles address decode, the read mux, STAT and irqout.

Test Plan:
- Reset, then read every register -> all read 0, irqout = 0; read at BASE+0x40 with NUM_CH = 4 -> 0.
- Ch0: TH = 0xFFFFFFFC, TL = 0xFFFFFFFC, PRE = 0, TCON = 0x3 -> TL reaches 0xFFFFFFFF after 3 cycles; next edge TL = 0xFFFFFFFC and flag = 1; irqout = 1 one cycle later.
- Ch1: PRE = 3, TL = 0, en = 1 -> TL increments once every 4 cycles; after 40 cycles TL = 10.
- Ch2 oneshot: TCON = 0x9, TL = 0xFFFFFFFF, TH = 5, PRE = 0 -> next edge TL = 5, flag = 1, en = 0; TL stays 5 for 20 cycles; irqout stays 0 (ie = 0); STAT = 0x4.
- Same-edge W1C (TCON write 0x7) and overflow on ch0 -> flag remains 1, irqout remains 1; a later W1C with no overflow -> irqout = 0 the next cycle.
- reset pulsed mid-count with 2 channels running -> TL = 0, TCON = 0 and irqout = 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel timer peripheral: register offsets
// within a channel block, the STAT offset and TCON bit positions.
package multi_timer_pkg;

  // Register offsets relative to a channel's base address
  localparam logic [31:0] OFF_TH    = 32'h0000_0000;
  localparam logic [31:0] OFF_TL    = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON  = 32'h0000_0008;
  localparam logic [31:0] OFF_PRE   = 32'h0000_000C;
  // STAT lives past the last possible channel block (8 * 16 bytes)
  localparam logic [31:0] OFF_STAT  = 32'h0000_0080;
  localparam int          CH_STRIDE = 16;
  localparam int          CH_SHIFT  = $clog2(CH_STRIDE);

  // TCON bit positions
  localparam int EN      = 0;
  localparam int IE      = 1;
  localparam int FLAG    = 2;
  localparam int ONESHOT = 3;

  // Assemble the four TCON bits in register order
  function automatic logic [3:0] tcon_pack(input logic en, input logic ie,
                                           input logic flag, input logic oneshot);
    logic [3:0] t;
    t          = 4'b0000;
    t[EN]      = en;
    t[IE]      = ie;
    t[FLAG]    = flag;
    t[ONESHOT] = oneshot;
    return t;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: TH reload, TL up-counter, prescaler and TCON state.
// Bus writes arrive as per-register write enables with the raw write data.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_th,
  input  logic        we_tl,
  input  logic        we_tcon,
  input  logic        we_pre,
  input  logic [31:0] wdata,
  output logic [31:0] th_rd,
  output logic [31:0] tl_rd,
  output logic [31:0] tcon_rd,
  output logic [31:0] pre_rd,
  output logic        flag,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  logic [CNT_W-1:0] th_q, th_d;
  logic [CNT_W-1:0] tl_q, tl_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic             en_q, en_d;
  logic             ie_q, ie_d;
  logic             flag_q, flag_d;
  logic             oneshot_q, oneshot_d;
  logic             tick_s;
  logic             ovf_s;

  // Next-state logic: prescaler, counter, reload and TCON updates
  always_comb begin
    tick_s = en_q && (pcnt_q == pre_q);
    // A TL write on the same edge suppresses overflow processing
    ovf_s  = tick_s && !we_tl && (tl_q == CNT_ONES);

    if (we_th) begin
      th_d = wdata[CNT_W-1:0];
    end else begin
      th_d = th_q;
    end

    // Reload uses the TH value held before this edge
    if (we_tl) begin
      tl_d = wdata[CNT_W-1:0];
    end else if (ovf_s) begin
      tl_d = th_q;
    end else if (tick_s) begin
      tl_d = tl_q + CNT_W'(1);
    end else begin
      tl_d = tl_q;
    end

    if (we_pre) begin
      pre_d = wdata[PRE_W-1:0];
    end else begin
      pre_d = pre_q;
    end

    if (we_pre || we_tcon) begin
      pcnt_d = '0;
    end else if (tick_s) begin
      pcnt_d = '0;
    end else if (en_q) begin
      pcnt_d = pcnt_q + PRE_W'(1);
    end else begin
      pcnt_d = pcnt_q;
    end

    // An explicit TCON write beats the one-shot auto-disable
    if (we_tcon) begin
      en_d = wdata[EN];
    end else if (ovf_s && oneshot_q) begin
      en_d = 1'b0;
    end else begin
      en_d = en_q;
    end

    if (we_tcon) begin
      ie_d      = wdata[IE];
      oneshot_d = wdata[ONESHOT];
    end else begin
      ie_d      = ie_q;
      oneshot_d = oneshot_q;
    end

    // Overflow set beats a write-1-to-clear on the same edge
    if (ovf_s) begin
      flag_d = 1'b1;
    end else if (we_tcon && wdata[FLAG]) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // Channel state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      pre_q     <= '0;
      pcnt_q    <= '0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      flag_q    <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      pre_q     <= pre_d;
      pcnt_q    <= pcnt_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      flag_q    <= flag_d;
      oneshot_q <= oneshot_d;
    end
  end

  // Zero-extended register views for the bus read mux
  always_comb begin
    th_rd   = 32'(th_q);
    tl_rd   = 32'(tl_q);
    pre_rd  = 32'(pre_q);
    tcon_rd = 32'(tcon_pack(en_q, ie_q, flag_q, oneshot_q));
    flag    = flag_q;
    irq     = flag_q & ie_q;
  end

endmodule

// File: rtl/multi_timer_periph.sv
// Multi-channel timer peripheral: address decode, per-channel write enables,
// combinational read mux, STAT register and combined interrupt output.
module multi_timer_periph
  import multi_timer_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter int          PRE_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  logic [31:0]       off_s;
  logic [NUM_CH-1:0] ch_hit_s;
  logic [NUM_CH-1:0] we_th_s, we_tl_s, we_tcon_s, we_pre_s;
  logic [NUM_CH-1:0] flag_s, irq_s;
  logic [31:0]       th_rd_s   [NUM_CH];
  logic [31:0]       tl_rd_s   [NUM_CH];
  logic [31:0]       tcon_rd_s [NUM_CH];
  logic [31:0]       pre_rd_s  [NUM_CH];
  logic [31:0]       sel_val_s;
  logic [31:0]       rd_val_s;
  logic              stat_hit_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_channel #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .we_th   (we_th_s[c]),
      .we_tl   (we_tl_s[c]),
      .we_tcon (we_tcon_s[c]),
      .we_pre  (we_pre_s[c]),
      .wdata   (wdata),
      .th_rd   (th_rd_s[c]),
      .tl_rd   (tl_rd_s[c]),
      .tcon_rd (tcon_rd_s[c]),
      .pre_rd  (pre_rd_s[c]),
      .flag    (flag_s[c]),
      .irq     (irq_s[c])
    );
  end

  // Decode the window offset into per-channel write strobes and read data
  always_comb begin
    off_s      = addr - BASE_ADDR;
    stat_hit_s = (off_s == OFF_STAT);
    rd_val_s   = {32{stat_hit_s}} & 32'(flag_s);
    sel_val_s  = 32'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      // Channel blocks are CH_STRIDE bytes apart; misaligned offsets miss
      ch_hit_s[c]  = (off_s[31:CH_SHIFT] == (32 - CH_SHIFT)'(c));
      we_th_s[c]   = wr && ch_hit_s[c] && (off_s[CH_SHIFT-1:0] == OFF_TH[CH_SHIFT-1:0]);
      we_tl_s[c]   = wr && ch_hit_s[c] && (off_s[CH_SHIFT-1:0] == OFF_TL[CH_SHIFT-1:0]);
      we_tcon_s[c] = wr && ch_hit_s[c] && (off_s[CH_SHIFT-1:0] == OFF_TCON[CH_SHIFT-1:0]);
      we_pre_s[c]  = wr && ch_hit_s[c] && (off_s[CH_SHIFT-1:0] == OFF_PRE[CH_SHIFT-1:0]);
      case (off_s[CH_SHIFT-1:0])
        OFF_TH[CH_SHIFT-1:0]:   sel_val_s = th_rd_s[c];
        OFF_TL[CH_SHIFT-1:0]:   sel_val_s = tl_rd_s[c];
        OFF_TCON[CH_SHIFT-1:0]: sel_val_s = tcon_rd_s[c];
        OFF_PRE[CH_SHIFT-1:0]:  sel_val_s = pre_rd_s[c];
        default:                sel_val_s = 32'h0;
      endcase
      rd_val_s = rd_val_s | ({32{ch_hit_s[c]}} & sel_val_s);
    end
    rdata  = rd ? rd_val_s : 32'h0;
    irqout = |irq_s;
  end

endmodule

// File: tb/tb_multi_timer_periph.sv
// Directed self-checking bench for multi_timer_periph (default parameters).
module tb_multi_timer_periph;

  localparam logic [31:0] BASE = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;
  int          total = 0;
  int          bad = 0;

  multi_timer_periph dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irqout (irqout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ra(input int c, input logic [31:0] off);
    return BASE + (32'(c) << 4) + off;
  endfunction

  // Write lands on the next rising edge; returns at the following falling edge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    rd   = 1'b1;
    #1;
    d  = rdata;
    rd = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd_reg(ra(c, 32'(r * 4)), v);
        total++;
        if (v !== 32'h0) begin
          bad++; $display("FAIL reset_reg ch%0d r%0d: got %h want 0", c, r, v);
        end
      end
    end
    rd_reg(BASE + 32'h80, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_stat: got %h want 0", v); end
    rd_reg(BASE + 32'h40, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_unmapped40: got %h want 0", v); end
    total++;
    if (irqout !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irqout); end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    bus_wr(ra(0, 32'h0), 32'hFFFF_FFFC);
    bus_wr(ra(0, 32'h4), 32'hFFFF_FFFC);
    bus_wr(ra(0, 32'hC), 32'h0);
    bus_wr(ra(0, 32'h8), 32'h3);
    repeat (3) @(negedge clk);
    rd_reg(ra(0, 32'h4), v);
    total++;
    if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ovf_tl_max: got %h want ffffffff", v); end
    total++;
    if (irqout !== 1'b0) begin bad++; $display("FAIL ovf_irq_early: got %b want 0", irqout); end
    @(negedge clk);
    rd_reg(ra(0, 32'h4), v);
    total++;
    if (v !== 32'hFFFF_FFFC) begin bad++; $display("FAIL ovf_tl_reload: got %h want fffffffc", v); end
    rd_reg(ra(0, 32'h8), v);
    total++;
    if (v !== 32'h7) begin bad++; $display("FAIL ovf_tcon: got %h want 7", v); end
    total++;
    if (irqout !== 1'b1) begin bad++; $display("FAIL ovf_irq: got %b want 1", irqout); end
    addr = ra(0, 32'h0); rd = 1'b0; #1;
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL rd_low_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_w1c;
    logic [31:0] v;
    repeat (3) @(negedge clk);
    rd_reg(ra(0, 32'h4), v);
    total++;
    if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL w1c_pre_tl: got %h want ffffffff", v); end
    bus_wr(ra(0, 32'h8), 32'h7);
    rd_reg(ra(0, 32'h8), v);
    total++;
    if (v !== 32'h7) begin bad++; $display("FAIL w1c_vs_ovf_tcon: got %h want 7", v); end
    total++;
    if (irqout !== 1'b1) begin bad++; $display("FAIL w1c_vs_ovf_irq: got %b want 1", irqout); end
    bus_wr(ra(0, 32'h8), 32'h7);
    rd_reg(ra(0, 32'h8), v);
    total++;
    if (v !== 32'h3) begin bad++; $display("FAIL w1c_clear_tcon: got %h want 3", v); end
    total++;
    if (irqout !== 1'b0) begin bad++; $display("FAIL w1c_clear_irq: got %b want 0", irqout); end
    bus_wr(ra(0, 32'h8), 32'h0);
  endtask

  task automatic test_prescaler;
    logic [31:0] v;
    bus_wr(ra(1, 32'hC), 32'hABCD_0003);
    bus_wr(ra(1, 32'h4), 32'h0);
    bus_wr(ra(1, 32'h8), 32'h1);
    repeat (39) @(negedge clk);
    rd_reg(ra(1, 32'h4), v);
    total++;
    if (v !== 32'd9) begin bad++; $display("FAIL pre_tl39: got %0d want 9", v); end
    @(negedge clk);
    rd_reg(ra(1, 32'h4), v);
    total++;
    if (v !== 32'd10) begin bad++; $display("FAIL pre_tl40: got %0d want 10", v); end
    rd_reg(ra(1, 32'hC), v);
    total++;
    if (v !== 32'h3) begin bad++; $display("FAIL pre_trunc: got %h want 3", v); end
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    bus_wr(ra(2, 32'h0), 32'h5);
    bus_wr(ra(2, 32'h4), 32'hFFFF_FFFF);
    bus_wr(ra(2, 32'hC), 32'h0);
    bus_wr(ra(2, 32'h8), 32'h9);
    rd_reg(ra(2, 32'h4), v);
    total++;
    if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL os_tl_before: got %h want ffffffff", v); end
    @(negedge clk);
    rd_reg(ra(2, 32'h4), v);
    total++;
    if (v !== 32'h5) begin bad++; $display("FAIL os_tl_reload: got %h want 5", v); end
    rd_reg(ra(2, 32'h8), v);
    total++;
    if (v !== 32'hC) begin bad++; $display("FAIL os_tcon: got %h want c", v); end
    rd_reg(BASE + 32'h80, v);
    total++;
    if (v !== 32'h4) begin bad++; $display("FAIL os_stat: got %h want 4", v); end
    repeat (20) @(negedge clk);
    rd_reg(ra(2, 32'h4), v);
    total++;
    if (v !== 32'h5) begin bad++; $display("FAIL os_tl_hold: got %h want 5", v); end
    total++;
    if (irqout !== 1'b0) begin bad++; $display("FAIL os_irq: got %b want 0", irqout); end
  endtask

  task automatic test_collisions;
    logic [31:0] v;
    @(negedge clk);
    bus_wr(ra(3, 32'h0), 32'h10);
    bus_wr(ra(3, 32'h4), 32'hFFFF_FFFE);
    bus_wr(ra(3, 32'hC), 32'h0);
    bus_wr(ra(3, 32'h8), 32'h1);
    @(negedge clk);
    bus_wr(ra(3, 32'h0), 32'h20);
    rd_reg(ra(3, 32'h4), v);
    total++;
    if (v !== 32'h10) begin bad++; $display("FAIL th_vs_ovf_tl: got %h want 10", v); end
    rd_reg(ra(3, 32'h0), v);
    total++;
    if (v !== 32'h20) begin bad++; $display("FAIL th_vs_ovf_th: got %h want 20", v); end
    rd_reg(BASE + 32'h80, v);
    total++;
    if (v !== 32'hC) begin bad++; $display("FAIL coll_stat: got %h want c", v); end
    bus_wr(ra(3, 32'h4), 32'h100);
    rd_reg(ra(3, 32'h4), v);
    total++;
    if (v !== 32'h100) begin bad++; $display("FAIL tl_wr_vs_tick: got %h want 100", v); end
    @(negedge clk);
    rd_reg(ra(3, 32'h4), v);
    total++;
    if (v !== 32'h101) begin bad++; $display("FAIL tl_after_wr: got %h want 101", v); end
    bus_wr(BASE + 32'h44, 32'h1234);
    rd_reg(BASE + 32'h44, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL unmapped_wr: got %h want 0", v); end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] v;
    @(negedge clk);
    bus_wr(ra(3, 32'h8), 32'h3);
    total++;
    if (irqout !== 1'b1) begin bad++; $display("FAIL pre_rst_irq: got %b want 1", irqout); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    rd_reg(ra(1, 32'h4), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL arst_tl1: got %h want 0", v); end
    rd_reg(ra(3, 32'h8), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL arst_tcon3: got %h want 0", v); end
    rd_reg(ra(3, 32'h4), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL arst_tl3: got %h want 0", v); end
    total++;
    if (irqout !== 1'b0) begin bad++; $display("FAIL arst_irq: got %b want 0", irqout); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    rd_reg(ra(1, 32'h4), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL post_rst_hold: got %h want 0", v); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_w1c();
    test_prescaler();
    test_oneshot();
    test_collisions();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
